// File: rtl/i2c_poll_scheduler_if.sv
// Bus bundle between the poll scheduler, the I2C byte engine and the packet consumer.
// The master side is the scheduler; the slave side is the engine plus consumer.
interface i2c_poll_scheduler_if;
   logic        i2c_start;
   logic [6:0]  i2c_addr;
   logic [7:0]  i2c_reg;
   logic        i2c_done;
   logic        i2c_err;
   logic [47:0] i2c_rdata;
   logic [79:0] pkt_data;
   logic        pkt_valid;
   logic        pkt_ready;

   modport master (
      output i2c_start, i2c_addr, i2c_reg, pkt_data, pkt_valid,
      input  i2c_done, i2c_err, i2c_rdata, pkt_ready
   );

   modport slave (
      input  i2c_start, i2c_addr, i2c_reg, pkt_data, pkt_valid,
      output i2c_done, i2c_err, i2c_rdata, pkt_ready
   );
endinterface

// File: rtl/i2c_poll_scheduler.sv
// Round-robin sensor poller: each 10 Hz tick reads 6 bytes from every enabled slot
// and emits one timestamped 80-bit packet per slot, in ascending slot order.
module i2c_poll_scheduler #(
   parameter int          N_SLOTS        = 4,
   parameter logic [27:0] SLOT_ADDR      = {7'h77, 7'h68, 7'h1E, 7'h48},
   parameter logic [31:0] SLOT_REG       = {8'hF7, 8'h3B, 8'h03, 8'h00},
   parameter int          TIMEOUT_CYCLES = 2000
) (
   input  logic                 clk_1mhz,
   input  logic                 rst_n,
   input  logic                 clk_10hz,
   input  logic [23:0]          timestamp,
   input  logic [3:0]           slot_en,
   output logic                 busy,
   output logic [7:0]           overrun_cnt,
   i2c_poll_scheduler_if.master bus
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      IDX_LAST = 2'(N_SLOTS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_START,
      ST_WAIT,
      ST_EMIT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       en_q, en_d;
   logic [23:0]      ts_q, ts_d;
   logic [6:0]       addr_q, addr_d;
   logic [7:0]       reg_q, reg_d;
   logic [79:0]      pkt_q, pkt_d;
   logic [7:0]       ovr_q, ovr_d;

   logic sync_p0, sync_p1, sync_p2;
   logic tick_p3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [79:0] make_pkt(input logic [23:0] ts,
                                            input logic [1:0]  slot,
                                            input logic        err,
                                            input logic [47:0] data);
      return {ts, slot, err, 5'b0, data};
   endfunction

   function automatic logic [6:0] addr_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return SLOT_ADDR[6:0];
         2'd1:    return SLOT_ADDR[13:7];
         2'd2:    return SLOT_ADDR[20:14];
         default: return SLOT_ADDR[27:21];
      endcase
   endfunction

   function automatic logic [7:0] reg_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return SLOT_REG[7:0];
         2'd1:    return SLOT_REG[15:8];
         2'd2:    return SLOT_REG[23:16];
         default: return SLOT_REG[31:24];
      endcase
   endfunction

   // Stages p0/p1 synchronise the slow clock, p2 holds the previous level, p3 is the tick.
   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         tick_p3 <= 1'b0;
      end else begin
         sync_p0 <= clk_10hz;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         tick_p3 <= sync_p1 & ~sync_p2;
      end
   end

   always_ff @(posedge clk_1mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         en_q    <= '0;
         ts_q    <= '0;
         addr_q  <= '0;
         reg_q   <= '0;
         pkt_q   <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         ts_q    <= ts_d;
         addr_q  <= addr_d;
         reg_q   <= reg_d;
         pkt_q   <= pkt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      ts_d    = ts_q;
      addr_d  = addr_q;
      reg_d   = reg_q;
      pkt_d   = pkt_q;
      ovr_d   = ovr_q;

      // A tick that lands mid-round is only counted, never restarts the round.
      if (tick_p3 && (state_q != ST_IDLE)) ovr_d = sat_inc8(ovr_q);

      unique case (state_q)
         ST_IDLE: begin
            if (tick_p3) begin
               en_d    = slot_en;
               ts_d    = timestamp;
               idx_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (en_q == 4'b0000) begin
               state_d = ST_IDLE;
            end else if (en_q[idx_q]) begin
               addr_d  = addr_of(idx_q);
               reg_d   = reg_of(idx_q);
               state_d = ST_START;
            end else if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // DONE wins over a timeout expiring in the same cycle.
            if (bus.i2c_done) begin
               pkt_d   = make_pkt(ts_q, idx_q, bus.i2c_err, bus.i2c_rdata);
               state_d = ST_EMIT;
            end else if (cnt_q == CNT_LAST) begin
               pkt_d   = make_pkt(ts_q, idx_q, 1'b1, 48'h0);
               state_d = ST_EMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_EMIT: begin
            if (bus.pkt_ready) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SCAN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.i2c_start = (state_q == ST_START);
   assign bus.i2c_addr  = addr_q;
   assign bus.i2c_reg   = reg_q;
   assign bus.pkt_valid = (state_q == ST_EMIT);
   assign bus.pkt_data  = pkt_q;
   assign busy          = (state_q != ST_IDLE);
   assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Bench for i2c_poll_scheduler: directed rounds plus randomised rounds checked against a
// round-level model (expected polls, packets, WAIT latency and overrun count).
module tb_i2c_poll_scheduler;
   localparam int TIMEOUT = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_10hz = 1'b0;
   logic [23:0] timestamp = '0;
   logic [3:0]  slot_en = '0;
   logic        busy;
   logic [7:0]  overrun_cnt;

   i2c_poll_scheduler_if bus ();

   i2c_poll_scheduler #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_1mhz   (clk),
      .rst_n      (rst_n),
      .clk_10hz   (clk_10hz),
      .timestamp  (timestamp),
      .slot_en    (slot_en),
      .busy       (busy),
      .overrun_cnt(overrun_cnt),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0]  exp_addr [4] = '{7'h48, 7'h1E, 7'h68, 7'h77};
   logic [7:0]  exp_reg  [4] = '{8'h00, 8'h03, 8'h3B, 8'hF7};
   int          dly_tab  [4];
   logic [47:0] rd_tab   [4];
   logic        err_tab  [4];
   int          ready_hold = 0;
   int          ovr_mode = 0;
   int          ovr_exp = 0;
   bit          stray_en = 1'b0;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i2c_done  = 1'b0;
         bus.pkt_ready = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_start"}, 80'(bus.i2c_start), 80'(0));
      check({pfx, "_valid"}, 80'(bus.pkt_valid), 80'(0));
      check({pfx, "_data"},  bus.pkt_data,       80'(0));
      check({pfx, "_addr"},  80'(bus.i2c_addr),  80'(0));
      check({pfx, "_reg"},   80'(bus.i2c_reg),   80'(0));
      check({pfx, "_busy"},  80'(busy),          80'(0));
      check({pfx, "_ovr"},   80'(overrun_cnt),   80'(0));
   endtask

   // One poll round: the model lists expected polls and packets, the loop plays the
   // I2C engine and the consumer and compares cycle by cycle.
   task automatic run_round(input logic [3:0] en, input logic [23:0] ts, input int budget);
      logic [79:0] exp_q[$];
      int          exp_slot[$];
      int cyc = 0, k = 0, cur = 0, hi_cnt = 0, lo_run = 0, vcnt = 0;
      int busy_cyc = 0, storm_n = 0, exp_lat = 0;
      bit pending = 1'b0, was_valid = 1'b0, acc_prev = 1'b0, ovr_done = 1'b0, ready = 1'b0;

      for (int s = 0; s < 4; s++)
         if (en[s]) begin
            exp_slot.push_back(s);
            if (dly_tab[s] <= TIMEOUT) exp_q.push_back({ts, 2'(s), err_tab[s], 5'b0, rd_tab[s]});
            else                       exp_q.push_back({ts, 2'(s), 1'b1, 5'b0, 48'h0});
         end

      idle(4);
      slot_en   = en;
      timestamp = ts;
      clk_10hz  = 1'b1;
      hi_cnt    = 8;

      while (cyc < 12 || exp_q.size() != 0 || busy) begin
         if (cyc >= budget) break;
         @(negedge clk);
         cyc++;
         if (hi_cnt > 0) begin
            hi_cnt--;
            if (hi_cnt == 0) clk_10hz = 1'b0;
         end
         lo_run = clk_10hz ? 0 : lo_run + 1;
         if (cyc >= 8) begin
            timestamp = 24'($urandom);
            slot_en   = 4'($urandom);
         end
         if (busy) busy_cyc++;
         bus.i2c_done  = 1'b0;
         bus.i2c_err   = 1'($urandom);
         bus.i2c_rdata = {16'($urandom), $urandom};

         if (bus.i2c_start) begin
            check("start_single", 80'(pending), 80'(0));
            if (exp_slot.size() == 0) check("extra_start", 80'(bus.i2c_start), 80'(0));
            else begin
               cur = exp_slot.pop_front();
               check("start_addr", 80'(bus.i2c_addr), 80'(exp_addr[cur]));
               check("start_reg",  80'(bus.i2c_reg),  80'(exp_reg[cur]));
               pending = 1'b1;
               k = 0;
            end
         end else if (pending) begin
            k++;
            if (k == dly_tab[cur]) begin
               bus.i2c_done  = 1'b1;
               bus.i2c_err   = err_tab[cur];
               bus.i2c_rdata = rd_tab[cur];
            end
            if (bus.pkt_valid) begin
               exp_lat = ((dly_tab[cur] <= TIMEOUT) ? dly_tab[cur] : TIMEOUT) + 1;
               check("wait_latency", 80'(k), 80'(exp_lat));
               pending = 1'b0;
            end else begin
               check("addr_hold", 80'(bus.i2c_addr), 80'(exp_addr[cur]));
               check("reg_hold",  80'(bus.i2c_reg),  80'(exp_reg[cur]));
            end
         end else if (stray_en && $urandom_range(0, 5) == 0) begin
            bus.i2c_done = 1'b1;
         end

         if (acc_prev)  check("valid_drop", 80'(bus.pkt_valid), 80'(0));
         if (was_valid) check("valid_hold", 80'(bus.pkt_valid), 80'(1));
         acc_prev = 1'b0;
         if (bus.pkt_valid) begin
            vcnt++;
            if (exp_q.size() == 0) check("extra_pkt", 80'(bus.pkt_valid), 80'(0));
            else                   check("pkt_data", bus.pkt_data, exp_q[0]);
            ready = (ready_hold >= 0) ? (vcnt > ready_hold) : ($urandom_range(0, 2) != 0);
            if (ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               acc_prev = 1'b1;
               vcnt = 0;
            end
            was_valid = !ready;
         end else begin
            ready = ($urandom_range(0, 1) == 1);
            was_valid = 1'b0;
            vcnt = 0;
         end
         bus.pkt_ready = ready;

         if (ovr_mode == 1 && pending && !ovr_done && k == 10 && dly_tab[cur] >= 30 && !clk_10hz) begin
            clk_10hz = 1'b1;
            hi_cnt   = 8;
            ovr_done = 1'b1;
            ovr_exp  = (ovr_exp < 255) ? ovr_exp + 1 : 255;
         end
         if (ovr_mode == 2 && pending && dly_tab[cur] > TIMEOUT && k >= 10 && storm_n < 300 &&
             !clk_10hz && lo_run >= 3) begin
            clk_10hz = 1'b1;
            hi_cnt   = 3;
            storm_n++;
            ovr_exp  = (ovr_exp < 255) ? ovr_exp + 1 : 255;
         end
      end

      clk_10hz = 1'b0;
      check("round_budget", 80'(cyc < budget), 80'(1));
      check("pkts_left",    80'(exp_q.size()), 80'(0));
      check("polls_left",   80'(exp_slot.size()), 80'(0));
      check("busy_end",     80'(busy), 80'(0));
      check("overrun_cnt",  80'(overrun_cnt), 80'(ovr_exp));
      if (en == 4'b0000) check("busy_len", 80'(busy_cyc <= 1), 80'(1));
   endtask

   initial begin
      #(400_000);
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      bus.i2c_done  = 1'b0;
      bus.i2c_err   = 1'b0;
      bus.i2c_rdata = '0;
      bus.pkt_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Two enabled slots, fixed response.
      for (int s = 0; s < 4; s++) begin
         dly_tab[s] = 700;
         rd_tab[s]  = 48'hA1A2A3A4A5A6;
         err_tab[s] = 1'b0;
      end
      run_round(4'b0101, 24'h000123, 4000);

      // No response at all: timeout packet.
      dly_tab[0] = 100000;
      run_round(4'b0001, 24'h0BEEF0, 4000);

      // Consumer stalls for 50 cycles.
      dly_tab[1] = 5;
      rd_tab[1]  = 48'h5A5A_1234_C3C3;
      ready_hold = 50;
      run_round(4'b0010, 24'h777777, 1000);
      ready_hold = 0;

      // Nothing enabled.
      run_round(4'b0000, 24'h111111, 100);

      // DONE exactly at expiry, then DONE one cycle too late; stray DONEs elsewhere.
      dly_tab[0] = TIMEOUT;
      rd_tab[0]  = 48'h0123_4567_89AB;
      err_tab[0] = 1'b0;
      dly_tab[1] = TIMEOUT + 1;
      rd_tab[1]  = 48'hFFFF_0000_FFFF;
      stray_en   = 1'b1;
      run_round(4'b0011, 24'hABCDEF, 6000);

      // Single overrun while waiting.
      dly_tab[0] = 300;
      rd_tab[0]  = 48'hDEAD_BEEF_0001;
      ovr_mode   = 1;
      run_round(4'b0001, 24'h000042, 2000);

      // Randomised rounds.
      ready_hold = -1;
      repeat (8) begin
         for (int s = 0; s < 4; s++) begin
            dly_tab[s] = $urandom_range(1, 60);
            rd_tab[s]  = {16'($urandom), $urandom};
            err_tab[s] = 1'($urandom);
         end
         ovr_mode = $urandom_range(0, 1);
         run_round(4'($urandom), 24'($urandom), 2000);
      end

      // Overrun storm saturates the counter.
      ready_hold = 0;
      dly_tab[0] = 100000;
      ovr_mode   = 2;
      run_round(4'b0001, 24'h0F0F0F, 6000);
      ovr_mode   = 0;

      // Reset in the middle of WAIT.
      idle(4);
      slot_en   = 4'b0001;
      timestamp = 24'h0ABCDE;
      clk_10hz  = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.i2c_start) seen = 1'b1;
      end
      clk_10hz = 1'b0;
      check("rst_round_started", 80'(seen), 80'(1));
      repeat (50) @(negedge clk);
      check("rst_pre_busy", 80'(busy), 80'(1));
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      ovr_exp = 0;
      @(negedge clk);
      bus.i2c_done  = 1'b1;
      bus.i2c_rdata = 48'h1111_2222_3333;
      @(negedge clk);
      bus.i2c_done = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      bus.i2c_done = 1'b1;
      @(negedge clk);
      bus.i2c_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_valid", 80'(bus.pkt_valid), 80'(0));
         check("post_rst_busy",  80'(busy), 80'(0));
      end

      // Fresh round after reset starts at slot 0.
      dly_tab[0] = 25;
      rd_tab[0]  = 48'h0000_CAFE_F00D;
      err_tab[0] = 1'b1;
      stray_en   = 1'b0;
      run_round(4'b0001, 24'h00BEEF, 500);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
